up_state_ctrl: RTL and testbench
================================

// Module: up_state_ctrl
// PURPOSE
//  uP-level state controller sitting directly upstream of the Core. Owns the boot phase:
//  streams a program image into memory via a valid/ready port, then releases the Core
//  (smIsBooted). Afterwards sequences pause/resume of the Core: a debug request or a Core HLT
//  starts a pause, and a resume pulse returns to RUN. Owns the memory port while booting and
//  passes the Core's port through afterwards.
// PARAMETERS
//  BOOT_WORDS  32768  number of 16-bit words loaded at boot (1..65536); 17-bit counter
// PORTS
//  i_clk            in   1   system clock; all state updates on its rising edge
//  i_rst            in   1   synchronous, active-high reset
//  i_bootData       in   16  boot image word
//  i_bootValid      in   1   i_bootData valid this cycle
//  o_bootReady      out  1   controller accepts a boot word this cycle
//  i_pauseReq       in   1   debug pause request (level)
//  i_resumeReq      in   1   debug resume request (level; rising edge acts)
//  i_coreHlt        in   1   Core reports HLT in execute
//  i_smNowPaused    in   1   Core confirms paused
//  o_smIsBooted     out  1   to Core: boot done, run allowed
//  o_smStartPause   out  1   to Core: enter/hold pause
//  i_coreMemAddr    in   16  Core memory address
//  i_coreMemData    in   16  Core write data
//  i_coreMemWr      in   1   Core write enable
//  o_memAddr        out  16  memory address (muxed)
//  o_memDataOut     out  16  memory write data (muxed)
//  o_memWr          out  1   memory write enable (muxed)
//  o_state          out  2   current state code (status LEDs)
// BEHAVIOUR
//  - States: BOOT=2'd0, RUN=2'd1, PAUSING=2'd2, PAUSED=2'd3. Reset -> BOOT, bootCnt=0, resumeQ=0.
//  - Reset outputs: o_smIsBooted=0, o_smStartPause=0, o_bootReady=0, o_memWr=0, o_state=0.
//  - All outputs decode from registered state; no combinational path from i_* to o_sm*.
//  - BOOT: o_bootReady=~i_rst. Word accepted when valid&ready.
//    - On accept: o_memAddr={bootCnt}, o_memDataOut=i_bootData, o_memWr=1 in the same cycle; bootCnt+1.
//    - Accept of word BOOT_WORDS-1 -> RUN next cycle. Invalid cycles stall with no write.
//    - Core memory inputs are ignored in BOOT.
//  - RUN: o_smIsBooted=1. Memory port = Core port, pure combinational pass-through.
//    - i_pauseReq|i_coreHlt -> PAUSING. Both in the same cycle -> a single PAUSING entry.
//  - PAUSING: o_smStartPause=1. i_smNowPaused=1 -> PAUSED. Resume requests are ignored.
//  - PAUSED: o_smStartPause stays 1, because the Core's pause flag is only a register of it.
//    - Rising edge of i_resumeReq (resumeQ=0, i_resumeReq=1) with i_pauseReq=0 -> RUN.
//    - Edge while i_pauseReq=1 is discarded; pause wins.
//  - HLT on resume: the Core clears HLT while startPause is high, so i_coreHlt=0 on return to RUN.
//    A HLT still visible in the first RUN cycle re-enters PAUSING.
//  - o_smIsBooted=1 in RUN, PAUSING, PAUSED; it never drops without i_rst.
//  - Reset mid-boot restarts the image at word 0. Reset mid-pause returns to BOOT and reloads.
//  - resumeQ registers i_resumeReq every cycle in every state.
// STRUCTURE
//  - Shared package up_pkg: state codes (ST_BOOT..ST_PAUSED), BOOT_WORDS default.
//  - One sub-module: boot_loader.
//    - Contains: bootCnt counter, handshake, done flag, boot memory-port drive.
//    - Top contains: FSM, resume edge detect, memory-port mux.
// TESTING
//  - Reset with BOOT_WORDS=4, stream 0xA000..0xA003 with valid gaps:
//    -> writes at addresses 0..3; o_smIsBooted=1 exactly one cycle after the 4th accept.
//  - Assert i_rst after 2 accepted words, then release
//    -> state=BOOT, next accept writes addr 0; no write during the i_rst cycle.
//  - RUN, i_coreHlt=1
//    -> o_smStartPause=1 next cycle; i_smNowPaused=1 -> o_state=3; o_smStartPause stays 1.
//  - PAUSED, i_resumeReq held 1 for 5 cycles -> one RUN transition; o_smStartPause=0 next cycle.
//  - PAUSED, i_pauseReq=1 plus resume edge -> stays PAUSED. In PAUSING, a resume edge -> ignored.
//  - RUN, Core drives addr 0x1234, data 0xBEEF, wr=1 -> identical values on o_mem* the same cycle.

Source files
------------

// File: rtl/up_pkg.sv
// Shared definitions for the uP state controller: state codes, boot sizing and
// small state-decode helpers used by the top-level output logic.
package up_pkg;

    typedef enum logic [1:0] {
        ST_BOOT    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSING = 2'd2,
        ST_PAUSED  = 2'd3
    } state_e;

    localparam int unsigned BOOT_WORDS_DEFAULT = 32768;
    localparam int unsigned BOOT_CNT_W         = 17;
    localparam int unsigned MEM_AW             = 16;
    localparam int unsigned MEM_DW             = 16;

    function automatic logic state_is_booted(input state_e s);
        return s != ST_BOOT;
    endfunction

    function automatic logic state_holds_pause(input state_e s);
        return (s == ST_PAUSING) || (s == ST_PAUSED);
    endfunction

endpackage

// File: rtl/boot_loader.sv
// Boot image loader: accepts BOOT_WORDS words over a valid/ready port and writes
// each one to consecutive memory addresses starting at 0.
module boot_loader
    import up_pkg::*;
#(
    parameter int unsigned BOOT_WORDS = BOOT_WORDS_DEFAULT
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic [MEM_DW-1:0] i_data,
    input  logic              i_valid,
    output logic              o_ready,
    output logic [MEM_AW-1:0] o_mem_addr,
    output logic [MEM_DW-1:0] o_mem_data,
    output logic              o_mem_wr,
    output logic              o_done
);

    localparam logic [BOOT_CNT_W-1:0] LastWord = BOOT_CNT_W'(BOOT_WORDS - 1);

    logic [BOOT_CNT_W-1:0] cnt_q, cnt_d;
    logic                  accept;

    // Ready drops during reset so a word presented in the reset cycle is never written.
    always_comb begin
        o_ready = i_en & ~i_rst;
        accept  = o_ready & i_valid;
        cnt_d   = cnt_q;
        if (accept) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        o_mem_addr = cnt_q[MEM_AW-1:0];
        o_mem_data = i_data;
        o_mem_wr   = accept;
        o_done     = accept && (cnt_q == LastWord);
    end

endmodule

// File: rtl/up_state_ctrl.sv
// uP-level state controller: boots the memory image, releases the Core, then
// sequences pause/resume of the Core and muxes the memory port.
module up_state_ctrl
    import up_pkg::*;
#(
    parameter int unsigned BOOT_WORDS = BOOT_WORDS_DEFAULT
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [MEM_DW-1:0] i_bootData,
    input  logic              i_bootValid,
    output logic              o_bootReady,
    input  logic              i_pauseReq,
    input  logic              i_resumeReq,
    input  logic              i_coreHlt,
    input  logic              i_smNowPaused,
    output logic              o_smIsBooted,
    output logic              o_smStartPause,
    input  logic [MEM_AW-1:0] i_coreMemAddr,
    input  logic [MEM_DW-1:0] i_coreMemData,
    input  logic              i_coreMemWr,
    output logic [MEM_AW-1:0] o_memAddr,
    output logic [MEM_DW-1:0] o_memDataOut,
    output logic              o_memWr,
    output logic [1:0]        o_state
);

    state_e state_q, state_d;
    logic   resume_q, resume_d;
    logic   resume_edge;

    logic [MEM_AW-1:0] boot_addr;
    logic [MEM_DW-1:0] boot_data;
    logic              boot_wr;
    logic              boot_done;

    boot_loader #(
        .BOOT_WORDS(BOOT_WORDS)
    ) u_boot_loader (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_en       (state_q == ST_BOOT),
        .i_data     (i_bootData),
        .i_valid    (i_bootValid),
        .o_ready    (o_bootReady),
        .o_mem_addr (boot_addr),
        .o_mem_data (boot_data),
        .o_mem_wr   (boot_wr),
        .o_done     (boot_done)
    );

    always_comb begin
        resume_d    = i_resumeReq;
        resume_edge = i_resumeReq & ~resume_q;
        state_d     = state_q;
        unique case (state_q)
            ST_BOOT: begin
                if (boot_done) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (i_pauseReq || i_coreHlt) begin
                    state_d = ST_PAUSING;
                end
            end
            ST_PAUSING: begin
                if (i_smNowPaused) begin
                    state_d = ST_PAUSED;
                end
            end
            ST_PAUSED: begin
                // A pending pause request outranks a resume edge in the same cycle.
                if (resume_edge && !i_pauseReq) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_BOOT;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= ST_BOOT;
            resume_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            resume_q <= resume_d;
        end
    end

    // Core status outputs decode purely from the state register.
    always_comb begin
        o_smIsBooted   = state_is_booted(state_q);
        o_smStartPause = state_holds_pause(state_q);
        o_state        = state_q;
    end

    always_comb begin
        o_memAddr    = i_coreMemAddr;
        o_memDataOut = i_coreMemData;
        o_memWr      = i_coreMemWr;
        if (state_q == ST_BOOT) begin
            o_memAddr    = boot_addr;
            o_memDataOut = boot_data;
            o_memWr      = boot_wr;
        end
    end

endmodule

// File: tb/tb_up_state_ctrl.sv
// Randomized bench for up_state_ctrl with a phase-level reference model
// (booted flag, accepted-word count, pause phase) checked every cycle.
module tb_up_state_ctrl;

    localparam int unsigned BW = 4;

    logic        clk;
    logic        rst;
    logic [15:0] boot_data;
    logic        boot_valid;
    logic        boot_ready;
    logic        pause_req;
    logic        resume_req;
    logic        core_hlt;
    logic        now_paused;
    logic        is_booted;
    logic        start_pause;
    logic [15:0] core_addr;
    logic [15:0] core_data;
    logic        core_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_data;
    logic        mem_wr;
    logic [1:0]  state;

    up_state_ctrl #(
        .BOOT_WORDS(BW)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_bootData     (boot_data),
        .i_bootValid    (boot_valid),
        .o_bootReady    (boot_ready),
        .i_pauseReq     (pause_req),
        .i_resumeReq    (resume_req),
        .i_coreHlt      (core_hlt),
        .i_smNowPaused  (now_paused),
        .o_smIsBooted   (is_booted),
        .o_smStartPause (start_pause),
        .i_coreMemAddr  (core_addr),
        .i_coreMemData  (core_data),
        .i_coreMemWr    (core_wr),
        .o_memAddr      (mem_addr),
        .o_memDataOut   (mem_data),
        .o_memWr        (mem_wr),
        .o_state        (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: phase 0 = running, 1 = pause requested, 2 = pause confirmed.
    bit m_known   = 0;
    bit m_booted  = 0;
    int m_words   = 0;
    int m_phase   = 0;
    bit m_prev_rs = 0;

    task automatic cycle();
        bit acc;
        @(negedge clk);
        if (m_known) begin
            acc = !m_booted && !rst && boot_valid;
            check_eq("state", 32'(state), m_booted ? 32'(m_phase + 1) : 32'd0);
            check_eq("is_booted", 32'(is_booted), 32'(m_booted));
            check_eq("start_pause", 32'(start_pause), 32'(m_booted && m_phase != 0));
            check_eq("boot_ready", 32'(boot_ready), 32'(!m_booted && !rst));
            if (!m_booted) begin
                check_eq("boot_wr", 32'(mem_wr), 32'(acc));
                if (acc) begin
                    check_eq("boot_addr", 32'(mem_addr), 32'(m_words));
                    check_eq("boot_data", 32'(mem_data), 32'(boot_data));
                end
            end else begin
                check_eq("pass_addr", 32'(mem_addr), 32'(core_addr));
                check_eq("pass_data", 32'(mem_data), 32'(core_data));
                check_eq("pass_wr", 32'(mem_wr), 32'(core_wr));
            end
        end
        @(posedge clk);
        if (rst) begin
            m_known   = 1;
            m_booted  = 0;
            m_words   = 0;
            m_phase   = 0;
            m_prev_rs = 0;
        end else begin
            if (!m_booted) begin
                if (boot_valid) begin
                    m_words++;
                    if (m_words == int'(BW)) m_booted = 1;
                end
            end else if (m_phase == 0) begin
                if (pause_req || core_hlt) m_phase = 1;
            end else if (m_phase == 1) begin
                if (now_paused) m_phase = 2;
            end else begin
                if (resume_req && !m_prev_rs && !pause_req) m_phase = 0;
            end
            m_prev_rs = resume_req;
        end
        #1;
    endtask

    // Streams n accepted words (with random valid gaps) of the 0xA000.. image.
    task automatic send_boot(input int n);
        int sent = 0;
        while (sent < n) begin
            boot_valid = ($urandom_range(0, 2) != 0);
            boot_data  = 16'hA000 + 16'(m_words);
            if (boot_valid) sent++;
            cycle();
        end
        boot_valid = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        boot_data  = '0;
        boot_valid = 1'b0;
        pause_req  = 1'b0;
        resume_req = 1'b0;
        core_hlt   = 1'b0;
        now_paused = 1'b0;
        core_addr  = '0;
        core_data  = '0;
        core_wr    = 1'b0;
        cycle();
        cycle();
        rst = 1'b0;

        // Partial boot, reset (with a valid word offered), then full boot.
        send_boot(2);
        rst        = 1'b1;
        boot_valid = 1'b1;
        cycle();
        rst        = 1'b0;
        boot_valid = 1'b0;
        cycle();
        send_boot(int'(BW));
        cycle();

        core_addr = 16'h1234;
        core_data = 16'hBEEF;
        core_wr   = 1'b1;
        cycle();
        core_wr = 1'b0;

        // HLT pause, resume edge while pausing, confirm, pause-wins, held resume.
        core_hlt = 1'b1;
        cycle();
        core_hlt = 1'b0;
        cycle();
        resume_req = 1'b1;
        cycle();
        resume_req = 1'b0;
        cycle();
        now_paused = 1'b1;
        cycle();
        now_paused = 1'b0;
        cycle();
        pause_req  = 1'b1;
        resume_req = 1'b1;
        cycle();
        cycle();
        resume_req = 1'b0;
        pause_req  = 1'b0;
        cycle();
        resume_req = 1'b1;
        repeat (5) cycle();
        resume_req = 1'b0;
        cycle();
        cycle();

        // Pause and HLT together, then HLT still visible in the first RUN cycle.
        pause_req = 1'b1;
        core_hlt  = 1'b1;
        cycle();
        pause_req  = 1'b0;
        core_hlt   = 1'b0;
        now_paused = 1'b1;
        cycle();
        now_paused = 1'b0;
        resume_req = 1'b1;
        cycle();
        core_hlt = 1'b1;
        cycle();
        core_hlt   = 1'b0;
        resume_req = 1'b0;
        cycle();
        cycle();

        for (int i = 0; i < 3000; i++) begin
            rst        = ($urandom_range(0, 399) == 0);
            boot_valid = ($urandom_range(0, 1) == 1);
            boot_data  = 16'($urandom);
            pause_req  = ($urandom_range(0, 15) == 0);
            core_hlt   = ($urandom_range(0, 15) == 0);
            now_paused = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 2) == 0) resume_req = ~resume_req;
            core_addr  = 16'($urandom);
            core_data  = 16'($urandom);
            core_wr    = ($urandom_range(0, 1) == 1);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
